sha256_msg_schedule: RTL and testbench

- Producer side of the per-round Wi/Ki interface of the SHA-256 compression round datapath.
- Accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready stream.
- Expands them into the 64-entry message schedule W0..W63 using a 16-word sliding window.
- Presents each Wi with its round constant Ki, one round per output handshake, to the round/compression controller.

---
 rtl/sha256_pkg.sv | 79 +++++++
 rtl/sha256_k_rom.sv | 14 +
 rtl/sha256_msg_schedule.sv | 116 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions.
// Contents:
//   WORD_W          - SHA-256 word width (32)
//   sched_state_t   - message-schedule FSM states
//   sched_ctl_t     - schedule control registers (state, load count, round)
//   K_TABLE         - the 64 SHA-256 round constants
//   rotr, s0, s1    - rotate-right and message-schedule sigma functions
//   big_sigma0/1, ch, maj - compression-round functions for the round datapath
package sha256_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    // Control registers kept together so the whole FSM context is visible
    // as one packed signal inside the schedule block.
    typedef struct packed {
        sched_state_t state;
        logic [3:0]   cnt;
        logic [5:0]   round;
    } sched_ctl_t;

    localparam logic [WORD_W-1:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                                input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] s0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] s1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x,
                                              input logic [WORD_W-1:0] y,
                                              input logic [WORD_W-1:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x,
                                               input logic [WORD_W-1:0] y,
                                               input logic [WORD_W-1:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round-constant lookup.
// Ports:
//   idx - round index 0..63
//   k   - K[idx], purely combinational
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]        idx,
    output logic [WORD_W-1:0] k
);

    assign k = K_TABLE[idx];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule producer.
// Loads one 512-bit block as 16 big-endian words (W0 first), then emits
// W0..W(ROUNDS-1) together with K[round], one round per output handshake,
// and pulses block_done for one cycle after the last round.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   in_valid, in_word, in_ready   - input word stream
//   out_valid, out_ready          - per-round output stream
//   out_Wi, out_Ki, out_round     - schedule word, round constant, round index
//   block_done                    - one-cycle pulse after the final round
// Parameter:
//   ROUNDS - rounds emitted per block, 16..64 (64 for standard SHA-256)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready, and the payload of an
// offered-but-unaccepted output stays stable until it is accepted.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_Wi,
    output logic [WORD_W-1:0] out_Ki,
    output logic [5:0]        out_round,
    output logic              block_done
);

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    sched_ctl_t        ctl;
    sched_state_t      state_nx;
    logic [WORD_W-1:0] w [16];
    logic [WORD_W-1:0] w_next;
    logic              load_xfer;
    logic              run_hs;

    // Window head w[0] is the word for the current round; w[15] receives the
    // word needed sixteen rounds from now.
    assign w_next = s1(w[14]) + w[9] + s0(w[1]) + w[0];

    always_comb begin
        state_nx   = ctl.state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        block_done = 1'b0;
        unique case (ctl.state)
            ST_LOAD: begin
                // Gated by rst so nothing is accepted while reset is held.
                in_ready = ~rst;
                if (in_valid && !rst && ctl.cnt == 4'd15) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                out_valid = 1'b1;
                if (out_ready && ctl.round == LAST_ROUND) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                block_done = 1'b1;
                state_nx   = ST_LOAD;
            end
            default: state_nx = ST_LOAD;
        endcase
    end

    assign load_xfer = in_valid & in_ready;
    assign run_hs    = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl.state <= ST_LOAD;
            ctl.cnt   <= 4'd0;
            ctl.round <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
        end else begin
            ctl.state <= state_nx;
            if (load_xfer) begin
                // cnt wraps 15 -> 0 on the last word, ready for the next block.
                w[ctl.cnt] <= in_word;
                ctl.cnt    <= ctl.cnt + 4'd1;
                ctl.round  <= 6'd0;
            end
            if (run_hs) begin
                for (int i = 0; i < 15; i++) begin
                    w[i] <= w[i+1];
                end
                w[15]     <= w_next;
                ctl.round <= ctl.round + 6'd1;
            end
            if (ctl.state == ST_DONE) begin
                ctl.round <= 6'd0;
            end
        end
    end

    assign out_Wi    = (ctl.state == ST_RUN) ? w[0] : '0;
    assign out_round = ctl.round;

    sha256_k_rom u_k_rom (
        .idx (ctl.round),
        .k   (out_Ki)
    );

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

    localparam int ROUNDS   = 64;
    localparam int ROUNDS_B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready, block_done;
    logic [31:0] in_word, out_Wi, out_Ki;
    logic [5:0]  out_round;

    logic        rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, block_done_b;
    logic [31:0] in_word_b, out_Wi_b, out_Ki_b;
    logic [5:0]  out_round_b;

    sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_Wi(out_Wi), .out_Ki(out_Ki),
        .out_round(out_round), .block_done(block_done)
    );

    sha256_msg_schedule #(.ROUNDS(ROUNDS_B)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_word(in_word_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_Wi(out_Wi_b), .out_Ki(out_Ki_b),
        .out_round(out_round_b), .block_done(block_done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_count = 0;
    int done_b_count = 0;
    int xfer_count = 0;

    logic [69:0] exp_q[$];
    logic [69:0] exp_b_q[$];

    logic [31:0] msg [16];
    logic [31:0] sched [64];

    logic [31:0] k_ref [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    function automatic logic [31:0] lsig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] lsig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_sched();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) sched[t] = msg[t];
            else sched[t] = lsig1(sched[t-2]) + sched[t-7] + lsig0(sched[t-15]) + sched[t-16];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Expected rounds for the main instance; the "abc" block also carries
    // hand-computed values at rounds 0, 16, 17 and 63.
    task automatic push_block(input bit abc);
        build_sched();
        for (int r = 0; r < ROUNDS; r++) begin
            logic [31:0] wv, kv;
            wv = sched[r];
            kv = k_ref[r];
            if (abc) begin
                if (r == 0)  begin wv = 32'h61626380; kv = 32'h428a2f98; end
                if (r == 16) wv = 32'h61626380;
                if (r == 17) wv = 32'h000f0000;
                if (r == 63) kv = 32'hc67178f2;
            end
            exp_q.push_back({6'(r), kv, wv});
        end
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    task automatic load_pattern(input logic [31:0] seed);
        for (int i = 0; i < 16; i++) msg[i] = seed * 32'(i + 1) + 32'h01234567;
    endtask

    // ---------------- driver tasks ----------------
    // Enters and leaves at posedge+1 with out_ready held low.
    task automatic send_block(input int max_gap, input bit hold_valid);
        xfer_count = 0;
        for (int i = 0; i < 16; i++) begin
            int gap;
            bit ok;
            int guard;
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                in_word  = 32'hdeadbeef;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_word  = msg[i];
            ok = 1'b0;
            guard = 0;
            while (!ok && guard < 100) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL load_timeout: word %0d not accepted, expected acceptance within 100 cycles", i);
            end
        end
        in_valid = hold_valid;
        in_word  = 32'hbad00bad;
        @(negedge clk);
        check("out_valid_after_16th", 32'(out_valid), 32'd1);
        check("in_ready_in_run", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        if (hold_valid) begin
            repeat (20) begin @(posedge clk); #1; end
            in_valid = 1'b0;
        end
    endtask

    task automatic run_block(input bit rnd);
        int cyc;
        int first;
        bit seen_done;
        cyc = 0;
        first = -1;
        seen_done = 1'b0;
        while (!seen_done && cyc < 3000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_valid && first < 0) first = cyc;
            if (block_done) seen_done = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        check("block_done_seen", 32'(seen_done), 32'd1);
        if (!rnd) check("run_cycles", 32'(cyc - 1 - first), 32'(ROUNDS));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("transfers_per_block", 32'(xfer_count), 32'd16);
    endtask

    // ---------------- monitor / scoreboard (main instance) ----------------
    logic        prev_stall, prev_last_hs, prev_done;
    logic [31:0] prev_wi, prev_ki;
    logic [5:0]  prev_round;

    initial begin : monitor
        logic [69:0] e;
        prev_stall = 0; prev_last_hs = 0; prev_done = 0;
        prev_wi = 0; prev_ki = 0; prev_round = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0; prev_last_hs = 0; prev_done = 0;
            end else begin
                if (in_valid && in_ready) xfer_count++;
                if (out_valid) check("in_ready_low_in_run", 32'(in_ready), 32'd0);
                if (prev_stall && out_valid) begin
                    check("stall_Wi_stable", out_Wi, prev_wi);
                    check("stall_Ki_stable", out_Ki, prev_ki);
                    check("stall_round_stable", 32'(out_round), 32'(prev_round));
                end
                if (block_done) begin
                    done_count++;
                    check("done_after_last_round", 32'(prev_last_hs), 32'd1);
                    check("done_single_cycle", 32'(prev_done), 32'd0);
                    check("out_valid_low_in_done", 32'(out_valid), 32'd0);
                end
                if (prev_done) check("in_ready_after_done", 32'(in_ready), 32'd1);
                prev_last_hs = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_round: got round %0d, expected no output", out_round);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("Wi[%0d]", e[69:64]), out_Wi, e[31:0]);
                        check($sformatf("Ki[%0d]", e[69:64]), out_Ki, e[63:32]);
                        check("round_index", 32'(out_round), 32'(e[69:64]));
                    end
                    prev_last_hs = (out_round == 6'(ROUNDS - 1));
                end
                prev_stall = out_valid && !out_ready;
                prev_wi    = out_Wi;
                prev_ki    = out_Ki;
                prev_round = out_round;
                prev_done  = block_done;
            end
        end
    end

    // ---------------- monitor / scoreboard (ROUNDS=16 instance) ----------------
    initial begin : monitor_b
        logic [69:0] e;
        logic last_b;
        last_b = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                last_b = 1'b0;
            end else begin
                if (block_done_b) begin
                    done_b_count++;
                    check("b_done_after_last_round", 32'(last_b), 32'd1);
                end
                last_b = 1'b0;
                if (out_valid_b && out_ready_b) begin
                    if (exp_b_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL b_unexpected_round: got round %0d, expected no output", out_round_b);
                    end else begin
                        e = exp_b_q.pop_front();
                        check($sformatf("b_Wi[%0d]", e[69:64]), out_Wi_b, e[31:0]);
                        check($sformatf("b_Ki[%0d]", e[69:64]), out_Ki_b, e[63:32]);
                        check("b_round_index", 32'(out_round_b), 32'(e[69:64]));
                    end
                    last_b = (out_round_b == 6'(ROUNDS_B - 1));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int guard;
        int done_before;
        rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
        rst_b = 1'b1; in_valid_b = 1'b0; in_word_b = '0; out_ready_b = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_Wi", out_Wi, 32'h0);
        check("rst_out_Ki", out_Ki, 32'h428a2f98);
        check("rst_out_round", 32'(out_round), 32'd0);
        check("rst_block_done", 32'(block_done), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // "abc" block, out_ready held high
        load_abc(); push_block(1'b1);
        send_block(0, 1'b0); run_block(1'b0);
        check("done_count_abc", 32'(done_count), 32'd1);

        // Same block under random backpressure
        load_abc(); push_block(1'b1);
        send_block(0, 1'b0); run_block(1'b1);
        check("done_count_backpressure", 32'(done_count), 32'd2);

        // Input gaps; in_valid held high during an initial stalled RUN stretch
        load_pattern(32'h9e3779b9); push_block(1'b0);
        send_block(3, 1'b1); run_block(1'b0);
        check("done_count_stalls", 32'(done_count), 32'd3);

        // Reset at round 30
        load_abc(); push_block(1'b1);
        send_block(0, 1'b0);
        done_before = done_count;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > ROUNDS - 30 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("round_before_reset", 32'(out_round), 32'd30);
        rst = 1'b1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_round", 32'(out_round), 32'd0);
        out_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_mid_reset", 32'(in_ready), 32'd1);
        check("no_done_on_reset", 32'(done_count), 32'(done_before));
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        push_block(1'b0);
        send_block(0, 1'b0); run_block(1'b0);
        check("done_count_after_reset", 32'(done_count), 32'd4);

        // Two consecutive blocks
        load_pattern(32'h5bd1e995); push_block(1'b0);
        send_block(0, 1'b0); run_block(1'b0);
        load_pattern(32'hcafef00d); push_block(1'b0);
        send_block(0, 1'b0); run_block(1'b0);
        check("done_count_two_blocks", 32'(done_count), 32'd6);

        // ROUNDS=16 instance: words come back unchanged, then block_done
        #1 rst_b = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) msg[i] = 32'h10203040 + 32'(i) * 32'h01010101;
        for (int r = 0; r < ROUNDS_B; r++) exp_b_q.push_back({6'(r), k_ref[r], msg[r]});
        out_ready_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bit ok;
            in_valid_b = 1'b1;
            in_word_b  = msg[i];
            ok = 1'b0;
            guard = 0;
            while (!ok && guard < 100) begin
                @(negedge clk);
                ok = in_ready_b;
                @(posedge clk); #1;
                guard++;
            end
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_load_timeout: word %0d not accepted, expected acceptance within 100 cycles", i);
            end
        end
        in_valid_b = 1'b0;
        guard = 0;
        while (done_b_count == 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("b_done_count", 32'(done_b_count), 32'd1);
        check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("b_done_count_final", 32'(done_b_count), 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_done_count", 32'(done_count), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
